// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage that sits directly after the program counter.
// It issues instruction-memory reads at pcaddr and registers each returned
// word into the IF/ID latch. When decode stalls, a one-entry skid buffer
// holds the next word. A flush discards any words fetched down the wrong
// path. fetch_accept tells the PC when it may advance.
//
// Optional feature: define FETCH_PERF_EN to add three 32-bit performance
// counters (perf_fetched, perf_stall, perf_squash). These counters never
// influence the datapath.
//
// Ports
//   CLK, RST          clock; synchronous active-high reset
//   pcaddr            current PC
//   imemREN/imemaddr  instruction read request / address (combinational)
//   ihit/imemload     memory returns a word this cycle
//   id_stall          decode cannot consume IF/ID this cycle
//   flush             redirect; squashes all younger words
//   fetch_accept      a word was captured this cycle (PC advance enable)
//   ifid_valid/instr/pc/npc   registered IF/ID latch
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] pcaddr,
  output logic              imemREN,
  output logic [ADDR_W-1:0] imemaddr,
  input  logic              ihit,
  input  logic [DATA_W-1:0] imemload,
  input  logic              id_stall,
  input  logic              flush,
  output logic              fetch_accept,
  output logic              ifid_valid,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [ADDR_W-1:0] ifid_npc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_squash
`endif
);

  typedef enum logic [0:0] {REQ = 1'b0, BUF = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(32'd4);

  state_t            state_r;
  logic              ifid_valid_r;
  logic [DATA_W-1:0] ifid_instr_r;
  logic [ADDR_W-1:0] ifid_pc_r;
  logic [ADDR_W-1:0] ifid_npc_r;
  logic              skid_valid_r;
  logic [DATA_W-1:0] skid_instr_r;
  logic [ADDR_W-1:0] skid_pc_r;

  logic              consume_s;
  logic              room_s;

  assign consume_s = ifid_valid_r & ~id_stall;
  // IF/ID can accept a new word if it is empty or is being drained this cycle.
  assign room_s    = ~ifid_valid_r | consume_s;
  assign imemaddr  = pcaddr;

  // Read request and accept strobe, gated off while in reset.
  always_comb begin
    imemREN      = 1'b0;
    fetch_accept = 1'b0;
    if (RST) begin
      imemREN      = 1'b0;
      fetch_accept = 1'b0;
    end else if (state_r == REQ) begin
      imemREN      = 1'b1;
      fetch_accept = ihit & ~flush;
    end else begin
      imemREN      = 1'b0;
      fetch_accept = 1'b0;
    end
  end

  // Fetch FSM, IF/ID latch and skid buffer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= REQ;
      ifid_valid_r <= 1'b0;
      ifid_instr_r <= '0;
      ifid_pc_r    <= '0;
      ifid_npc_r   <= '0;
      skid_valid_r <= 1'b0;
      skid_instr_r <= '0;
      skid_pc_r    <= '0;
    end else if (flush) begin
      // Wrong-path words are dropped; the next cycle fetches the new pcaddr.
      ifid_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      state_r      <= REQ;
    end else begin
      case (state_r)
        REQ: begin
          if (ihit) begin
            if (room_s) begin
              ifid_valid_r <= 1'b1;
              ifid_instr_r <= imemload;
              ifid_pc_r    <= pcaddr;
              ifid_npc_r   <= pcaddr + PC_STEP;
            end else begin
              // Decode is stalled: park the word and stop requesting.
              skid_valid_r <= 1'b1;
              skid_instr_r <= imemload;
              skid_pc_r    <= pcaddr;
              state_r      <= BUF;
            end
          end else if (consume_s) begin
            ifid_valid_r <= 1'b0;
          end
        end
        BUF: begin
          if (consume_s) begin
            ifid_valid_r <= 1'b1;
            ifid_instr_r <= skid_instr_r;
            ifid_pc_r    <= skid_pc_r;
            ifid_npc_r   <= skid_pc_r + PC_STEP;
            skid_valid_r <= 1'b0;
            state_r      <= REQ;
          end
        end
        default: begin
          state_r      <= REQ;
          ifid_valid_r <= 1'b0;
          skid_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign ifid_valid = ifid_valid_r;
  assign ifid_instr = ifid_instr_r;
  assign ifid_pc    = ifid_pc_r;
  assign ifid_npc   = ifid_npc_r;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_r;
  logic [31:0] perf_stall_r;
  logic [31:0] perf_squash_r;

  // Free-running event counters; they wrap naturally at 2^32.
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_fetched_r <= 32'd0;
      perf_stall_r   <= 32'd0;
      perf_squash_r  <= 32'd0;
    end else begin
      if (fetch_accept) begin
        perf_fetched_r <= perf_fetched_r + 32'd1;
      end
      if ((imemREN & ~ihit) | (state_r == BUF)) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
      if (flush & (ifid_valid_r | skid_valid_r | ihit)) begin
        perf_squash_r <= perf_squash_r + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_r;
  assign perf_stall   = perf_stall_r;
  assign perf_squash  = perf_squash_r;
`endif

endmodule
